prog_loader: RTL

Byte-stream program loader sitting directly upstream of the 8-bit CPU core. It receives a framed program image (length, payload, checksum) over a valid/ready byte interface and writes the payload into the CPU's 32x8 memory starting at address 0. It holds the CPU in reset (`cpu_rst_n` low) while loading, and releases it only after the checksum verifies, so the CPU always boots from a complete, verified image.

---
 rtl/prog_loader.sv | 105 ++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// Byte-stream program loader: receives a length/payload/checksum frame, writes the
// payload into CPU memory from address 0 and releases CPU reset only on a good checksum.
module prog_loader #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              rx_valid,
   output logic              rx_ready,
   input  logic [DATA_W-1:0] rx_data,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data,
   output logic              mem_wr,
   output logic              cpu_rst_n,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LEN  = 3'd1;
   localparam logic [2:0] S_DATA = 3'd2;
   localparam logic [2:0] S_CSUM = 3'd3;
   localparam logic [2:0] S_RUN  = 3'd4;
   localparam logic [2:0] S_ERR  = 3'd5;

   localparam logic [DATA_W-1:0] MAX_LEN = DATA_W'(1 << ADDR_W);

   logic [2:0]        state;
   logic [2:0]        state_nxt;
   logic [ADDR_W-1:0] cnt;
   logic [ADDR_W-1:0] last;
   logic [DATA_W-1:0] sum;
   logic              accept;
   logic              loading_nxt;

   assign accept      = rx_valid & rx_ready;
   assign loading_nxt = (state_nxt == S_LEN) || (state_nxt == S_DATA) || (state_nxt == S_CSUM);

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_RUN, S_ERR: begin
            if (start) state_nxt = S_LEN;
         end
         S_LEN: begin
            if (accept) begin
               if ((rx_data == '0) || (rx_data > MAX_LEN)) state_nxt = S_ERR;
               else                                        state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            if (accept && (cnt == last)) state_nxt = S_CSUM;
         end
         S_CSUM: begin
            if (accept) state_nxt = (rx_data == sum) ? S_RUN : S_ERR;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Status outputs are registered from the next state so they change together with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         rx_ready  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         cpu_rst_n <= 1'b0;
         err       <= 1'b0;
         mem_wr    <= 1'b0;
         mem_addr  <= '0;
         mem_data  <= '0;
         cnt       <= '0;
         last      <= '0;
         sum       <= '0;
      end else begin
         state     <= state_nxt;
         rx_ready  <= loading_nxt;
         busy      <= loading_nxt;
         done      <= (state_nxt == S_RUN);
         cpu_rst_n <= (state_nxt == S_RUN);
         err       <= (state_nxt == S_ERR);
         mem_wr    <= 1'b0;

         if ((state == S_LEN) && accept) begin
            cnt  <= '0;
            sum  <= '0;
            last <= ADDR_W'(rx_data - DATA_W'(1));
         end

         // The counter holds at the last address so it can never wrap past 31.
         if ((state == S_DATA) && accept) begin
            mem_wr   <= 1'b1;
            mem_addr <= cnt;
            mem_data <= rx_data;
            sum      <= sum + rx_data;
            if (cnt != last) cnt <= cnt + ADDR_W'(1);
         end
      end
   end

endmodule
